// File: rtl/slave_cpl_recorder_reader.sv
// Completion-side reader for the request recorder: looks up each completion tag,
// classifies the result, and frees the recorder entry when the tag is finished.
module slave_cpl_recorder_reader #(
  parameter int TAG_W   = 8,
  parameter int ENTRY_W = 32
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               cpl_valid,
  output logic               cpl_ready,
  input  logic [TAG_W-1:0]   cpl_tag,
  input  logic               cpl_last,
  input  logic [2:0]         cpl_status,
  output logic               req_rd_en,
  output logic [TAG_W-1:0]   req_rd_addr,
  input  logic [ENTRY_W-1:0] req_rd_data,
  output logic               req_free_en,
  output logic [TAG_W-1:0]   req_free_addr,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ENTRY_W-2:0] rsp_entry,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_last,
  output logic [1:0]         rsp_err
);

  typedef enum logic [1:0] {IDLE, LOOKUP, CAPTURE, RESPOND} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [TAG_W-1:0]   r_tag;
  logic               r_last;
  logic [2:0]         r_status;
  logic [ENTRY_W-2:0] r_entry;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic               r_rsp_last;
  logic [1:0]         r_err;
  logic               r_free;
  logic               w_accept;
  logic               w_hs;

  assign w_accept = cpl_valid && cpl_ready;
  assign w_hs     = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = LOOKUP;
      LOOKUP:  w_next = CAPTURE;
      CAPTURE: w_next = RESPOND;
      RESPOND: if (w_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // An invalid entry means nobody is waiting for this tag, so that verdict
  // overrides the completer status and never frees the entry.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_tag      <= '0;
      r_last     <= 1'b0;
      r_status   <= 3'b000;
      r_entry    <= '0;
      r_rsp_tag  <= '0;
      r_rsp_last <= 1'b0;
      r_err      <= 2'b00;
      r_free     <= 1'b0;
    end else begin
      if (r_state == IDLE && w_accept) begin
        r_tag    <= cpl_tag;
        r_last   <= cpl_last;
        r_status <= cpl_status;
      end
      if (r_state == CAPTURE) begin
        r_entry   <= req_rd_data[ENTRY_W-2:0];
        r_rsp_tag <= r_tag;
        if (!req_rd_data[ENTRY_W-1]) begin
          r_err      <= 2'b10;
          r_rsp_last <= 1'b1;
          r_free     <= 1'b0;
        end else if (r_status != 3'b000) begin
          r_err      <= 2'b01;
          r_rsp_last <= 1'b1;
          r_free     <= 1'b1;
        end else begin
          r_err      <= 2'b00;
          r_rsp_last <= r_last;
          r_free     <= r_last;
        end
      end
    end
  end

  assign cpl_ready     = (r_state == IDLE);
  assign req_rd_en     = (r_state == LOOKUP);
  assign req_rd_addr   = req_rd_en ? r_tag : '0;
  assign rsp_valid     = (r_state == RESPOND);
  assign rsp_entry     = r_entry;
  assign rsp_tag       = r_rsp_tag;
  assign rsp_last      = r_rsp_last;
  assign rsp_err       = r_err;
  assign req_free_en   = w_hs && r_free;
  assign req_free_addr = req_free_en ? r_rsp_tag : '0;

endmodule
